fetch_control: RTL and testbench
================================

Name: fetch_control

Overview:
- Sequencing FSM for the exp6 fetch datapath.
- Drives register load enables, bus gate selects and SRAM control strobes so the datapath runs instruction fetch cycles: MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR.
- Started by Run; pauses after every fetch until Continue.
- Sits between the top-level buttons and the datapath/SRAM pins.

Parameters:
- MEM_WAIT, 2: extra SRAM read wait cycles before MDR capture (0..15).
- MAX_FETCH, 0: fetches before automatic return to HALT; 0 = unlimited.

Ports:
- Clk  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Run  input  1  level, active-high start button; rising-edge detected internally.
- Continue  input  1  level, active-high resume button; rising-edge detected internally.
- load_mar  output  1  MAR load enable.
- load_pc  output  1  PC load enable (PC+1 path).
- load_mdr  output  1  MDR load enable.
- load_ir  output  1  IR load enable.
- gate_pc  output  1  PC tri-state drive onto Data.
- gate_mdr  output  1  MDR tri-state drive onto Data.
- mem_ce_n  output  1  SRAM chip enable, active-low.
- mem_oe_n  output  1  SRAM output enable, active-low.
- mem_we_n  output  1  SRAM write enable, active-low; constant 1 in this block.
- halted  output  1  high in HALT state.
- state_code  output  3  current state encoding, for hex display/debug.
- fetch_count  output  16  completed fetches since reset, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (Reset=0, async):
  - state=HALT; fetch_count=0.
  - All load_* and gate_* = 0; mem_ce_n=mem_oe_n=mem_we_n=1; halted=1.
  - Edge-detect history regs = 1, so a button held through reset produces no edge.
- Edge detect: run_edge = Run & ~Run_q; cont_edge = Continue & ~Continue_q; history updated every cycle.
- Outputs are Moore-decoded from state (plus wait counter in F2); no combinational path from Run/Continue to outputs.
- States, with state_code values:
  - HALT (0): all strobes inactive. run_edge -> F1.
  - F1 (1): gate_pc=1, load_mar=1, load_pc=1. One cycle -> F2. Wait counter loaded with MEM_WAIT.
  - F2 (2): mem_ce_n=0, mem_oe_n=0.
    - Counter decrements each cycle while nonzero.
    - In the cycle the counter is 0: load_mdr=1; next state F3.
    - F2 lasts exactly MEM_WAIT+1 cycles.
  - F3 (3): gate_mdr=1, load_ir=1. One cycle; fetch_count increments on exit.
    - If MAX_FETCH!=0 and the incremented count equals MAX_FETCH: -> HALT.
    - Otherwise -> PAUSE.
  - PAUSE (4): all strobes inactive. cont_edge -> F1; run_edge ignored.
    - Simultaneous Run and Continue edges: Continue wins.
- Ignored inputs:
  - run_edge outside HALT is ignored.
  - cont_edge outside PAUSE is ignored, and is not remembered.
- Encodings 5-7 are illegal; they decode to HALT outputs and next state HALT.
- Invariants:
  - gate_pc & gate_mdr never both 1.
  - load_mdr only while mem_oe_n=0.
  - Exactly one each of load_mar/load_pc/load_mdr/load_ir pulse per fetch.
- Fetch latency from run_edge/cont_edge detection to load_ir pulse: MEM_WAIT+3 cycles (F1, F2 x(MEM_WAIT+1), F3).
- Reset asserted mid-fetch (any state): immediate return to HALT with reset values; partial fetch abandoned, fetch_count cleared.
- fetch_count wrap: no flag. With MAX_FETCH=0, wrap is silent.

Test Plan:
- Reset, hold Run=1 through deassert, never toggle -> stays HALT, halted=1, state_code=0, all strobes inactive.
- MEM_WAIT=2, pulse Run once -> F1 1 cycle (gate_pc, load_mar, load_pc), F2 3 cycles with mem_oe_n=0 and load_mdr only in the 3rd, F3 1 cycle (load_ir) -> PAUSE; fetch_count=1.
- In PAUSE, pulse Continue 3 times spaced 10 cycles -> 3 further fetch sequences; fetch_count=4; Run pulses between them have no effect.
- MAX_FETCH=2: Run, then one Continue -> after 2nd F3, state HALT, halted=1, fetch_count=2; a further Continue is ignored; a Run starts fetch 3.
- Assert Reset during F2 cycle 2 -> same cycle all strobes inactive, state_code=0, fetch_count=0; after release, a new Run completes a clean fetch.
- Run and Continue rising in the same cycle while in PAUSE -> exactly one fetch begins; during whole run, gate_pc&gate_mdr==0 and mem_we_n==1 every cycle.

Source files
------------

// File: rtl/fetch_control_if.sv
// Button/strobe bundle between fetch_control and the exp6 datapath/SRAM.
// The master modport is the controller side; slave is the datapath/button side.
interface fetch_control_if;
  logic        Run;
  logic        Continue;
  logic        load_mar;
  logic        load_pc;
  logic        load_mdr;
  logic        load_ir;
  logic        gate_pc;
  logic        gate_mdr;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        halted;
  logic [2:0]  state_code;
  logic [15:0] fetch_count;

  modport master (
    input  Run, Continue,
    output load_mar, load_pc, load_mdr, load_ir, gate_pc, gate_mdr,
    output mem_ce_n, mem_oe_n, mem_we_n, halted, state_code, fetch_count
  );

  modport slave (
    output Run, Continue,
    input  load_mar, load_pc, load_mdr, load_ir, gate_pc, gate_mdr,
    input  mem_ce_n, mem_oe_n, mem_we_n, halted, state_code, fetch_count
  );
endinterface

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer for the exp6 datapath:
// MAR<-PC / PC<-PC+1, MDR<-M[MAR] after MEM_WAIT extra cycles, IR<-MDR,
// then pause until Continue. Strobes are registered, decoded from the
// next state so they line up with the state register.
module fetch_control #(
  parameter int MEM_WAIT  = 2,
  parameter int MAX_FETCH = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  fetch_control_if.master  bus
);

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_F1    = 3'd1,
    ST_F2    = 3'd2,
    ST_F3    = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  typedef struct packed {
    logic load_mar;
    logic load_pc;
    logic load_mdr;
    logic load_ir;
    logic gate_pc;
    logic gate_mdr;
    logic mem_ce_n;
    logic mem_oe_n;
    logic mem_we_n;
    logic halted;
  } strobe_t;

  localparam logic [3:0]  WAIT_INIT = 4'(MEM_WAIT);
  localparam logic [15:0] MAX_CNT   = 16'(MAX_FETCH);
  localparam logic        MAX_EN    = (MAX_FETCH != 0);

  // Strobe decode for a (state, wait counter) pair; unknown states look like HALT.
  function automatic strobe_t decode(input state_t st, input logic [3:0] cnt);
    strobe_t s;
    s = '{load_mar: 1'b0, load_pc: 1'b0, load_mdr: 1'b0, load_ir: 1'b0,
          gate_pc: 1'b0, gate_mdr: 1'b0, mem_ce_n: 1'b1, mem_oe_n: 1'b1,
          mem_we_n: 1'b1, halted: 1'b0};
    case (st)
      ST_HALT: begin
        s.halted = 1'b1;
      end
      ST_F1: begin
        s.gate_pc  = 1'b1;
        s.load_mar = 1'b1;
        s.load_pc  = 1'b1;
      end
      ST_F2: begin
        s.mem_ce_n = 1'b0;
        s.mem_oe_n = 1'b0;
        s.load_mdr = (cnt == 4'd0);
      end
      ST_F3: begin
        s.gate_mdr = 1'b1;
        s.load_ir  = 1'b1;
      end
      ST_PAUSE: begin
        s.halted = 1'b0;
      end
      default: begin
        s.halted = 1'b1;
      end
    endcase
    return s;
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_next_s;
  logic [15:0]   fetch_count_r;
  logic [15:0]   count_next_s;
  logic          run_q_r;
  logic          cont_q_r;
  logic          run_edge_s;
  logic          cont_edge_s;
  strobe_t       out_r;
  strobe_t       out_next_s;

  assign run_edge_s  = bus.Run & ~run_q_r;
  assign cont_edge_s = bus.Continue & ~cont_q_r;

  // Next-state, wait-counter and fetch-count logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    count_next_s = fetch_count_r;
    case (state_r)
      ST_HALT: begin
        if (run_edge_s) begin
          state_next_s = ST_F1;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      ST_F1: begin
        state_next_s = ST_F2;
        cnt_next_s   = WAIT_INIT;
      end
      ST_F2: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_F3;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_F3: begin
        count_next_s = fetch_count_r + 16'd1;
        if (MAX_EN && (count_next_s == MAX_CNT)) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        // Continue alone resumes; a coincident Run edge changes nothing.
        if (cont_edge_s) begin
          state_next_s = ST_F1;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      default: begin
        state_next_s = ST_HALT;
        cnt_next_s   = 4'd0;
      end
    endcase
    out_next_s = decode(state_next_s, cnt_next_s);
  end

  // State, counters, button history and registered strobes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r       <= ST_HALT;
      cnt_r         <= 4'd0;
      fetch_count_r <= 16'd0;
      run_q_r       <= 1'b1;
      cont_q_r      <= 1'b1;
      out_r         <= decode(ST_HALT, 4'd0);
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      fetch_count_r <= count_next_s;
      run_q_r       <= bus.Run;
      cont_q_r      <= bus.Continue;
      out_r         <= out_next_s;
    end
  end

  assign bus.load_mar    = out_r.load_mar;
  assign bus.load_pc     = out_r.load_pc;
  assign bus.load_mdr    = out_r.load_mdr;
  assign bus.load_ir     = out_r.load_ir;
  assign bus.gate_pc     = out_r.gate_pc;
  assign bus.gate_mdr    = out_r.gate_mdr;
  assign bus.mem_ce_n    = out_r.mem_ce_n;
  assign bus.mem_oe_n    = out_r.mem_oe_n;
  assign bus.mem_we_n    = out_r.mem_we_n;
  assign bus.halted      = out_r.halted;
  assign bus.state_code  = state_r;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: dut_a (MEM_WAIT=2, unlimited fetches)
// and dut_b (MEM_WAIT=0, MAX_FETCH=2) on a shared clock and reset.
module tb_fetch_control;

  logic Clk;
  logic Reset;
  int   tests;
  int   fails;
  int   viol;

  // Strobe vector order: mar pc mdr ir gpc gmdr ce_n oe_n we_n halted
  localparam logic [9:0] S_HALT  = 10'b0000_00_111_1;
  localparam logic [9:0] S_F1    = 10'b1100_10_111_0;
  localparam logic [9:0] S_F2W   = 10'b0000_00_001_0;
  localparam logic [9:0] S_F2M   = 10'b0010_00_001_0;
  localparam logic [9:0] S_F3    = 10'b0001_01_111_0;
  localparam logic [9:0] S_PAUSE = 10'b0000_00_111_0;

  fetch_control_if bus_a ();
  fetch_control_if bus_b ();

  fetch_control #(.MEM_WAIT(2), .MAX_FETCH(0)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a)
  );
  fetch_control #(.MEM_WAIT(0), .MAX_FETCH(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus_b)
  );

  // 10-time-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [9:0] strb_a();
    return {bus_a.load_mar, bus_a.load_pc, bus_a.load_mdr, bus_a.load_ir,
            bus_a.gate_pc, bus_a.gate_mdr, bus_a.mem_ce_n, bus_a.mem_oe_n,
            bus_a.mem_we_n, bus_a.halted};
  endfunction

  function automatic logic [9:0] strb_b();
    return {bus_b.load_mar, bus_b.load_pc, bus_b.load_mdr, bus_b.load_ir,
            bus_b.gate_pc, bus_b.gate_mdr, bus_b.mem_ce_n, bus_b.mem_oe_n,
            bus_b.mem_we_n, bus_b.halted};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Per-cycle safety properties on both instances.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if ((bus_a.gate_pc & bus_a.gate_mdr) !== 1'b0) viol++;
      if ((bus_b.gate_pc & bus_b.gate_mdr) !== 1'b0) viol++;
      if (bus_a.mem_we_n !== 1'b1) viol++;
      if (bus_b.mem_we_n !== 1'b1) viol++;
      if (bus_a.load_mdr === 1'b1 && bus_a.mem_oe_n !== 1'b0) viol++;
      if (bus_b.load_mdr === 1'b1 && bus_b.mem_oe_n !== 1'b0) viol++;
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    viol  = 0;
    Reset = 1'b0;
    bus_a.Run = 1'b1;        // held through reset: must not start
    bus_a.Continue = 1'b0;
    bus_b.Run = 1'b0;
    bus_b.Continue = 1'b0;

    // Reset values
    step();
    check("rst_strobes", 32'(strb_a()), 32'(S_HALT));
    check("rst_state", 32'(bus_a.state_code), 32'd0);
    check("rst_count", 32'(bus_a.fetch_count), 32'd0);
    step();
    Reset = 1'b1;
    repeat (5) step();
    check("held_run_state", 32'(bus_a.state_code), 32'd0);
    check("held_run_halted", 32'(bus_a.halted), 32'd1);
    check("held_run_strobes", 32'(strb_a()), 32'(S_HALT));

    // First fetch, MEM_WAIT=2
    bus_a.Run = 1'b0;
    step();
    bus_a.Run = 1'b1;
    step();
    check("f1_state", 32'(bus_a.state_code), 32'd1);
    check("f1_strobes", 32'(strb_a()), 32'(S_F1));
    bus_a.Run = 1'b0;
    step();
    check("f2a_state", 32'(bus_a.state_code), 32'd2);
    check("f2a_strobes", 32'(strb_a()), 32'(S_F2W));
    step();
    check("f2b_strobes", 32'(strb_a()), 32'(S_F2W));
    step();
    check("f2c_strobes", 32'(strb_a()), 32'(S_F2M));
    step();
    check("f3_state", 32'(bus_a.state_code), 32'd3);
    check("f3_strobes", 32'(strb_a()), 32'(S_F3));
    check("f3_count", 32'(bus_a.fetch_count), 32'd0);
    step();
    check("pause_state", 32'(bus_a.state_code), 32'd4);
    check("pause_strobes", 32'(strb_a()), 32'(S_PAUSE));
    check("pause_count", 32'(bus_a.fetch_count), 32'd1);

    // Three Continue-driven fetches, Run pulses in between ignored
    for (int i = 0; i < 3; i++) begin
      bus_a.Continue = 1'b1;
      step();
      check("cont_f1", 32'(bus_a.state_code), 32'd1);
      bus_a.Continue = 1'b0;
      repeat (4) step();
      check("cont_f3", 32'(strb_a()), 32'(S_F3));
      step();
      check("cont_count", 32'(bus_a.fetch_count), 32'(i + 2));
      bus_a.Run = 1'b1;
      step();
      bus_a.Run = 1'b0;
      step();
      check("run_in_pause", 32'(bus_a.state_code), 32'd4);
      repeat (2) step();
    end
    check("cont_total", 32'(bus_a.fetch_count), 32'd4);

    // Continue edge during F2 is not remembered
    bus_a.Continue = 1'b1;
    step();
    bus_a.Continue = 1'b0;
    step();
    bus_a.Continue = 1'b1;
    step();
    bus_a.Continue = 1'b0;
    repeat (4) step();
    check("cont_not_kept_state", 32'(bus_a.state_code), 32'd4);
    check("cont_not_kept_count", 32'(bus_a.fetch_count), 32'd5);

    // Run and Continue together in PAUSE: exactly one fetch
    bus_a.Run = 1'b1;
    bus_a.Continue = 1'b1;
    step();
    check("both_f1", 32'(bus_a.state_code), 32'd1);
    bus_a.Run = 1'b0;
    bus_a.Continue = 1'b0;
    repeat (5) step();
    check("both_state", 32'(bus_a.state_code), 32'd4);
    check("both_count", 32'(bus_a.fetch_count), 32'd6);
    repeat (3) step();
    check("both_single", 32'(bus_a.fetch_count), 32'd6);

    // Reset asserted in the second F2 cycle
    bus_a.Continue = 1'b1;
    step();
    bus_a.Continue = 1'b0;
    step();
    step();
    check("pre_rst_f2", 32'(bus_a.state_code), 32'd2);
    Reset = 1'b0;
    #1;
    check("midrst_strobes", 32'(strb_a()), 32'(S_HALT));
    check("midrst_state", 32'(bus_a.state_code), 32'd0);
    check("midrst_count", 32'(bus_a.fetch_count), 32'd0);
    Reset = 1'b1;
    step();
    step();
    bus_a.Run = 1'b1;
    step();
    check("post_rst_f1", 32'(strb_a()), 32'(S_F1));
    bus_a.Run = 1'b0;
    repeat (3) step();
    check("post_rst_mdr", 32'(strb_a()), 32'(S_F2M));
    step();
    check("post_rst_f3", 32'(strb_a()), 32'(S_F3));
    step();
    check("post_rst_count", 32'(bus_a.fetch_count), 32'd1);

    // dut_b: MEM_WAIT=0, MAX_FETCH=2
    check("b_idle", 32'(bus_b.state_code), 32'd0);
    bus_b.Run = 1'b1;
    step();
    check("b_f1", 32'(strb_b()), 32'(S_F1));
    bus_b.Run = 1'b0;
    step();
    check("b_f2_mdr", 32'(strb_b()), 32'(S_F2M));
    step();
    check("b_f3", 32'(strb_b()), 32'(S_F3));
    step();
    check("b_pause", 32'(bus_b.state_code), 32'd4);
    check("b_count1", 32'(bus_b.fetch_count), 32'd1);
    bus_b.Continue = 1'b1;
    step();
    bus_b.Continue = 1'b0;
    repeat (3) step();
    check("b_max_state", 32'(bus_b.state_code), 32'd0);
    check("b_max_halted", 32'(bus_b.halted), 32'd1);
    check("b_max_count", 32'(bus_b.fetch_count), 32'd2);
    bus_b.Continue = 1'b1;
    step();
    bus_b.Continue = 1'b0;
    step();
    check("b_cont_ignored", 32'(bus_b.state_code), 32'd0);
    bus_b.Run = 1'b1;
    step();
    check("b_run3_f1", 32'(bus_b.state_code), 32'd1);
    bus_b.Run = 1'b0;
    repeat (3) step();
    check("b_count3", 32'(bus_b.fetch_count), 32'd3);
    check("b_count3_state", 32'(bus_b.state_code), 32'd4);

    check("invariants", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
